// File: rtl/dlx_global_pkg.sv
// Shared DLX definitions: opcode encodings, register index type, ID/EX pipeline record
// and opcode-class helpers used by the decode stage.
package dlx_global_pkg;

  typedef logic [4:0] dlx_reg_idx;
  typedef logic [5:0] dlx_op_t;

  localparam dlx_op_t OP_RTYPE = 6'h00;
  localparam dlx_op_t OP_J     = 6'h02;
  localparam dlx_op_t OP_JAL   = 6'h03;
  localparam dlx_op_t OP_BEQZ  = 6'h04;
  localparam dlx_op_t OP_BNEZ  = 6'h05;
  localparam dlx_op_t OP_ADDI  = 6'h08;
  localparam dlx_op_t OP_ANDI  = 6'h0C;
  localparam dlx_op_t OP_ORI   = 6'h0D;
  localparam dlx_op_t OP_XORI  = 6'h0E;
  localparam dlx_op_t OP_LHI   = 6'h0F;
  localparam dlx_op_t OP_JR    = 6'h12;
  localparam dlx_op_t OP_JALR  = 6'h13;
  localparam dlx_op_t OP_LB    = 6'h20;
  localparam dlx_op_t OP_LH    = 6'h21;
  localparam dlx_op_t OP_LW    = 6'h23;
  localparam dlx_op_t OP_LBU   = 6'h24;
  localparam dlx_op_t OP_LHU   = 6'h25;
  localparam dlx_op_t OP_SB    = 6'h28;
  localparam dlx_op_t OP_SH    = 6'h29;
  localparam dlx_op_t OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    dlx_reg_idx  rd;
    dlx_op_t     op;
    logic [5:0]  func;
    logic [31:0] npc;
    logic        wr_en;
    logic        load;
  } id_ex_t;

  function automatic logic is_load(input dlx_op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input dlx_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Immediate ALU ops: 0x08-0x0F and the shift/set-immediate block 0x14-0x1D (0x15 unused).
  function automatic logic is_ialu(input dlx_op_t op);
    return (op inside {[6'h08:6'h0F]}) || ((op inside {[6'h14:6'h1D]}) && op != 6'h15);
  endfunction

endpackage

// File: rtl/dlx_regfile.sv
// DLX general register file: two combinational read ports, one write port,
// r0 hardwired to zero, same-cycle write-through to the read ports.
module dlx_regfile #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  ra1,
  input  logic [IDX_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (we && wa != '0) mem[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : mem[ra2];

endmodule

// File: rtl/dlx_pipe_id.sv
// DLX instruction-decode stage: register read, decode, branch/jump resolution,
// hazard stall generation and the ID/EX pipeline register.
module dlx_pipe_id
  import dlx_global_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int LINK_REG = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dc_wait,
  input  logic [31:0] if_id_ir,
  input  logic [31:0] if_id_npc,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_load,
  output logic        stall,
  output logic [31:0] id_npc,
  output logic        id_cond,
  output logic [31:0] id_ex_a,
  output logic [31:0] id_ex_b,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rd,
  output logic [5:0]  id_ex_op,
  output logic [5:0]  id_ex_func,
  output logic [31:0] id_ex_npc,
  output logic        id_ex_wr_en,
  output logic        id_ex_load
);

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic signed [31:0] sext26(input logic [25:0] v);
    return {{6{v[25]}}, v};
  endfunction

  dlx_op_t     op;
  dlx_reg_idx  rs1, rs2, rd_r;
  logic [31:0] a_val, b_val;
  id_ex_t      dec_p0, id_ex_p1;

  logic               is_br, is_jr, is_jmp, use_rs1, use_rs2, taken, hz_load, hz_br;
  logic signed [31:0] imm_p0, target_p0;
  dlx_reg_idx         rd_p0;

  assign op   = if_id_ir[31:26];
  assign rs1  = if_id_ir[25:21];
  assign rs2  = if_id_ir[20:16];
  assign rd_r = if_id_ir[15:11];

  dlx_regfile #(.NREGS(NREGS), .DATA_W(32)) u_rf (
    .clk (clk),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (a_val),
    .rd2 (b_val),
    .we  (wb_en),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // ---- p0: decode, branch resolution and hazard detection ----
  always_comb begin
    is_br   = (op == OP_BEQZ) || (op == OP_BNEZ);
    is_jr   = (op == OP_JR) || (op == OP_JALR);
    is_jmp  = (op == OP_J) || (op == OP_JAL);
    use_rs2 = (op == OP_RTYPE) || is_store(op);
    use_rs1 = (op == OP_RTYPE) || (is_ialu(op) && op != OP_LHI) || is_load(op) ||
              is_store(op) || is_br || is_jr;

    rd_p0 = '0;
    if (op == OP_RTYPE)                rd_p0 = rd_r;
    else if (is_ialu(op) || is_load(op)) rd_p0 = rs2;
    else if (op == OP_JAL || op == OP_JALR) rd_p0 = dlx_reg_idx'(LINK_REG);

    imm_p0 = sext16(if_id_ir[15:0]);
    if (op inside {OP_ANDI, OP_ORI, OP_XORI}) imm_p0 = {16'h0, if_id_ir[15:0]};
    else if (is_jmp)                          imm_p0 = sext26(if_id_ir[25:0]);

    taken     = 1'b0;
    target_p0 = $signed(if_id_npc) + imm_p0;
    case (op)
      OP_BEQZ:         taken = (a_val == '0);
      OP_BNEZ:         taken = (a_val != '0);
      OP_J, OP_JAL:    taken = 1'b1;
      OP_JR, OP_JALR: begin
        taken     = 1'b1;
        target_p0 = $signed(a_val);
      end
      default:         taken = 1'b0;
    endcase

    hz_load = id_ex_p1.load && (id_ex_p1.rd != '0) &&
              ((use_rs1 && id_ex_p1.rd == rs1) || (use_rs2 && id_ex_p1.rd == rs2));
    hz_br   = (is_br || is_jr) && (rs1 != '0) &&
              ((id_ex_p1.wr_en && id_ex_p1.rd == rs1) || (ex_mem_load && ex_mem_rd == rs1));

    dec_p0.a     = a_val;
    dec_p0.b     = b_val;
    dec_p0.imm   = imm_p0;
    dec_p0.rd    = rd_p0;
    dec_p0.op    = op;
    dec_p0.func  = if_id_ir[5:0];
    dec_p0.npc   = if_id_npc;
    dec_p0.wr_en = (rd_p0 != '0);
    dec_p0.load  = is_load(op);
  end

  assign stall   = hz_load || hz_br;
  assign id_cond = taken && !stall && !dc_wait;
  assign id_npc  = id_cond ? target_p0 : 32'h0;

  // ---- p1: ID/EX register; cache miss freezes it, a stall inserts a bubble ----
  always_ff @(posedge clk) begin
    if (rst)           id_ex_p1 <= '0;
    else if (!dc_wait) id_ex_p1 <= stall ? '0 : dec_p0;
  end

  assign id_ex_a     = id_ex_p1.a;
  assign id_ex_b     = id_ex_p1.b;
  assign id_ex_imm   = id_ex_p1.imm;
  assign id_ex_rd    = id_ex_p1.rd;
  assign id_ex_op    = id_ex_p1.op;
  assign id_ex_func  = id_ex_p1.func;
  assign id_ex_npc   = id_ex_p1.npc;
  assign id_ex_wr_en = id_ex_p1.wr_en;
  assign id_ex_load  = id_ex_p1.load;

endmodule

// File: tb/tb_dlx_pipe_id.sv
// Directed, table-driven bench for the DLX decode stage plus hand sequences for
// cache freeze, write-through and reset in the middle of a load-use stall.
module tb_dlx_pipe_id;

  localparam logic [5:0] C_J = 6'h02, C_JAL = 6'h03, C_BEQZ = 6'h04, C_BNEZ = 6'h05;
  localparam logic [5:0] C_ADDI = 6'h08, C_ORI = 6'h0D, C_XORI = 6'h0E;
  localparam logic [5:0] C_JR = 6'h12, C_JALR = 6'h13, C_LW = 6'h23, C_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20;

  logic        clk = 1'b0;
  logic        rst, dc_wait, wb_en, ex_mem_load;
  logic [31:0] if_id_ir, if_id_npc, wb_data;
  logic [4:0]  wb_rd, ex_mem_rd;
  logic        stall, id_cond, id_ex_wr_en, id_ex_load;
  logic [31:0] id_npc, id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;
  logic [4:0]  id_ex_rd;
  logic [5:0]  id_ex_op, id_ex_func;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlx_pipe_id #(.NREGS(32), .LINK_REG(31)) dut (
    .clk         (clk),
    .rst         (rst),
    .dc_wait     (dc_wait),
    .if_id_ir    (if_id_ir),
    .if_id_npc   (if_id_npc),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_load (ex_mem_load),
    .stall       (stall),
    .id_npc      (id_npc),
    .id_cond     (id_cond),
    .id_ex_a     (id_ex_a),
    .id_ex_b     (id_ex_b),
    .id_ex_imm   (id_ex_imm),
    .id_ex_rd    (id_ex_rd),
    .id_ex_op    (id_ex_op),
    .id_ex_func  (id_ex_func),
    .id_ex_npc   (id_ex_npc),
    .id_ex_wr_en (id_ex_wr_en),
    .id_ex_load  (id_ex_load)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  em_rd;
    logic        em_load;
    logic        stall;
    logic        cond;
    logic [31:0] tgt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        ma;
    logic        mb;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs1, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs1, rs2, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] off);
    return {op, off};
  endfunction

  function automatic vec_t mk(
    input logic [31:0] ir, input logic [31:0] npc, input logic we, input logic [4:0] wr_idx,
    input logic [31:0] wd, input logic [4:0] emr, input logic eml, input logic s, input logic c,
    input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
    input logic [4:0] rd, input logic wr, input logic ld, input logic ma, input logic mb);
    vec_t v;
    v.ir = ir; v.npc = npc; v.wb_en = we; v.wb_rd = wr_idx; v.wb_data = wd;
    v.em_rd = emr; v.em_load = eml; v.stall = s; v.cond = c; v.tgt = tgt;
    v.a = a; v.b = b; v.imm = imm; v.rd = rd; v.wr = wr; v.ld = ld; v.ma = ma; v.mb = mb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        t;
    logic [31:0] exp_npc;
    logic [5:0]  exp_op;

    // ir, npc, wb_en, wb_rd, wb_data, em_rd, em_load | stall, cond, tgt | a, b, imm, rd, wr, ld, check_a, check_b
    tbl.push_back(mk(32'h0, 32'h04, 1, 5'd1, 32'd5, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_ADDI, 1, 2, 16'hFFFD), 32'h08, 1, 5'd3, 32'h33, 0, 0,
                     0, 0, 0,  5, 0, 32'hFFFFFFFD, 2, 1, 0, 1, 0));
    tbl.push_back(mk(enc_i(C_ORI, 0, 6, 16'h8000), 32'h0C, 0, 0, 0, 0, 0,
                     0, 0, 0,  0, 0, 32'h00008000, 6, 1, 0, 1, 0));
    tbl.push_back(mk(enc_i(C_ADDI, 7, 8, 16'h0001), 32'h10, 1, 5'd7, 32'hDEADBEEF, 0, 0,
                     0, 0, 0,  32'hDEADBEEF, 0, 1, 8, 1, 0, 1, 0));
    tbl.push_back(mk(enc_i(C_ADDI, 0, 9, 16'h0000), 32'h14, 1, 5'd0, 32'h1234, 0, 0,
                     0, 0, 0,  0, 0, 0, 9, 1, 0, 1, 0));
    tbl.push_back(mk(enc_i(C_LW, 1, 3, 16'h0000), 32'h18, 0, 0, 0, 0, 0,
                     0, 0, 0,  5, 0, 0, 3, 1, 1, 1, 0));
    tbl.push_back(mk(enc_r(3, 3, 4, F_ADD), 32'h1C, 0, 0, 0, 0, 0,
                     1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(enc_r(3, 3, 4, F_ADD), 32'h1C, 0, 0, 0, 0, 0,
                     0, 0, 0,  32'h33, 32'h33, 32'h2020, 4, 1, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_BEQZ, 0, 0, 16'h0008), 32'h100, 0, 0, 0, 0, 0,
                     0, 1, 32'h108,  0, 0, 8, 0, 0, 0, 1, 0));
    tbl.push_back(mk(enc_i(C_BNEZ, 0, 0, 16'h0008), 32'h104, 0, 0, 0, 0, 0,
                     0, 0, 0,  0, 0, 8, 0, 0, 0, 1, 0));
    tbl.push_back(mk(enc_j(C_JAL, 26'h3FFFFFC), 32'h20, 0, 0, 0, 0, 0,
                     0, 1, 32'h1C,  0, 0, 32'hFFFFFFFC, 31, 1, 0, 0, 0));
    tbl.push_back(mk(enc_i(C_ADDI, 0, 5, 16'h0400), 32'h24, 0, 0, 0, 0, 0,
                     0, 0, 0,  0, 0, 32'h400, 5, 1, 0, 1, 0));
    tbl.push_back(mk(enc_i(C_JR, 5, 0, 16'h0000), 32'h28, 1, 5'd5, 32'h400, 0, 0,
                     1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_JR, 5, 0, 16'h0000), 32'h28, 0, 0, 0, 5, 0,
                     0, 1, 32'h400,  32'h400, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_BNEZ, 1, 0, 16'h0010), 32'h2C, 0, 0, 0, 1, 1,
                     1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_JALR, 1, 0, 16'h0000), 32'h44, 0, 0, 0, 0, 0,
                     0, 1, 32'h5,  5, 0, 0, 31, 1, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_SW, 1, 3, 16'h0004), 32'h48, 0, 0, 0, 0, 0,
                     0, 0, 0,  5, 32'h33, 4, 0, 0, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_LW, 0, 7, 16'h0000), 32'h4C, 0, 0, 0, 0, 0,
                     0, 0, 0,  0, 0, 0, 7, 1, 1, 1, 0));
    tbl.push_back(mk(enc_i(C_SW, 0, 7, 16'h0000), 32'h50, 0, 0, 0, 0, 0,
                     1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_LW, 0, 11, 16'h0000), 32'h50, 0, 0, 0, 0, 0,
                     0, 0, 0,  0, 0, 0, 11, 1, 1, 1, 0));
    tbl.push_back(mk(enc_i(C_ADDI, 0, 11, 16'h0001), 32'h54, 0, 0, 0, 0, 0,
                     0, 0, 0,  0, 0, 1, 11, 1, 0, 1, 0));
    tbl.push_back(mk(enc_i(C_BEQZ, 11, 0, 16'hFFF8), 32'h58, 0, 0, 0, 0, 0,
                     1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(enc_i(C_BEQZ, 1, 0, 16'hFFF8), 32'h60, 0, 0, 0, 0, 0,
                     0, 0, 0,  5, 0, 32'hFFFFFFF8, 0, 0, 0, 1, 0));
    tbl.push_back(mk(enc_i(C_BNEZ, 1, 0, 16'hFFF8), 32'h60, 0, 0, 0, 0, 0,
                     0, 1, 32'h58,  5, 0, 32'hFFFFFFF8, 0, 0, 0, 1, 0));
    tbl.push_back(mk(enc_j(C_J, 26'h0000020), 32'hFFFFFFF0, 0, 0, 0, 0, 0,
                     0, 1, 32'h10,  0, 0, 32'h20, 0, 0, 0, 0, 0));
    tbl.push_back(mk(enc_i(C_XORI, 1, 12, 16'hFFFF), 32'h64, 0, 0, 0, 0, 0,
                     0, 0, 0,  5, 0, 32'h0000FFFF, 12, 1, 0, 1, 0));

    rst = 1; dc_wait = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    ex_mem_rd = 0; ex_mem_load = 0; if_id_ir = 0; if_id_npc = 0;
    tick();
    chk("reset id_ex_a", id_ex_a, 0);
    chk("reset id_ex_b", id_ex_b, 0);
    chk("reset id_ex_imm", id_ex_imm, 0);
    chk("reset id_ex_rd", 32'(id_ex_rd), 0);
    chk("reset id_ex_op", 32'(id_ex_op), 0);
    chk("reset id_ex_func", 32'(id_ex_func), 0);
    chk("reset id_ex_npc", id_ex_npc, 0);
    chk("reset id_ex_wr_en", 32'(id_ex_wr_en), 0);
    chk("reset id_ex_load", 32'(id_ex_load), 0);
    chk("reset stall", 32'(stall), 0);
    chk("reset id_cond", 32'(id_cond), 0);
    rst = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      if_id_ir = t.ir; if_id_npc = t.npc;
      wb_en = t.wb_en; wb_rd = t.wb_rd; wb_data = t.wb_data;
      ex_mem_rd = t.em_rd; ex_mem_load = t.em_load;
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(t.stall));
      chk($sformatf("v%0d id_cond", i), 32'(id_cond), 32'(t.cond));
      chk($sformatf("v%0d id_npc", i), id_npc, t.tgt);
      tick();
      exp_op  = t.stall ? 6'h00 : t.ir[31:26];
      exp_npc = t.stall ? 32'h0 : t.npc;
      if (t.ma) chk($sformatf("v%0d id_ex_a", i), id_ex_a, t.a);
      if (t.mb) chk($sformatf("v%0d id_ex_b", i), id_ex_b, t.b);
      chk($sformatf("v%0d id_ex_imm", i), id_ex_imm, t.imm);
      chk($sformatf("v%0d id_ex_rd", i), 32'(id_ex_rd), 32'(t.rd));
      chk($sformatf("v%0d id_ex_wr_en", i), 32'(id_ex_wr_en), 32'(t.wr));
      chk($sformatf("v%0d id_ex_load", i), 32'(id_ex_load), 32'(t.ld));
      chk($sformatf("v%0d id_ex_op", i), 32'(id_ex_op), 32'(exp_op));
      chk($sformatf("v%0d id_ex_npc", i), id_ex_npc, exp_npc);
      if (t.stall || t.ir[31:26] == 6'h00)
        chk($sformatf("v%0d id_ex_func", i), 32'(id_ex_func), t.stall ? 32'h0 : 32'(t.ir[5:0]));
    end

    // Cache-miss freeze: ID/EX holds, no redirect, register writes still land.
    wb_en = 0; ex_mem_rd = 0; ex_mem_load = 0;
    if_id_ir = enc_i(C_ADDI, 1, 13, 16'h0007); if_id_npc = 32'h70;
    tick();
    chk("freeze setup rd", 32'(id_ex_rd), 13);
    if_id_ir = enc_i(C_BEQZ, 0, 0, 16'h0008); if_id_npc = 32'h200;
    dc_wait = 1; wb_en = 1; wb_rd = 14; wb_data = 32'h77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("freeze%0d id_cond", k), 32'(id_cond), 0);
      chk($sformatf("freeze%0d id_npc", k), id_npc, 0);
      tick();
      wb_en = 0;
      chk($sformatf("freeze%0d rd", k), 32'(id_ex_rd), 13);
      chk($sformatf("freeze%0d a", k), id_ex_a, 5);
      chk($sformatf("freeze%0d imm", k), id_ex_imm, 7);
      chk($sformatf("freeze%0d npc", k), id_ex_npc, 32'h70);
      chk($sformatf("freeze%0d wr_en", k), 32'(id_ex_wr_en), 1);
    end
    dc_wait = 0;
    if_id_ir = enc_i(C_ADDI, 14, 15, 16'h0000); if_id_npc = 32'h74;
    @(negedge clk);
    chk("unfreeze stall", 32'(stall), 0);
    tick();
    chk("unfreeze a", id_ex_a, 32'h77);
    chk("unfreeze rd", 32'(id_ex_rd), 15);

    // Reset while a load-use stall is pending.
    if_id_ir = enc_i(C_LW, 0, 16, 16'h0000); if_id_npc = 32'h80;
    tick();
    if_id_ir = enc_r(16, 16, 17, F_ADD); if_id_npc = 32'h84;
    @(negedge clk);
    chk("midrst stall before", 32'(stall), 1);
    rst = 1;
    tick();
    chk("midrst rd", 32'(id_ex_rd), 0);
    chk("midrst load", 32'(id_ex_load), 0);
    chk("midrst npc", id_ex_npc, 0);
    @(negedge clk);
    chk("midrst stall after", 32'(stall), 0);
    rst = 0;
    tick();
    chk("midrst add rd", 32'(id_ex_rd), 17);
    chk("midrst add wr_en", 32'(id_ex_wr_en), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
